// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC32 constants, block size default and packer state type
package crc_pkg;

  // Words per CRC block unless the instantiating design overrides it.
  localparam int WORDS_PER_BLOCK_DEF = 101;

  // Reflected CRC32 polynomial and the init/xorout value used by the CRC stage.
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  // FILL accepts bytes, GAP holds off the source after a completed block.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_GAP  = 1'b1
  } pack_state_t;

  // Drop one byte into its lane of a word; lane 0 is the most significant byte.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  value);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[31:24] = value;
      2'd1:    r[23:16] = value;
      2'd2:    r[15:8]  = value;
      default: r[7:0]   = value;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crc_word_packer.sv
// rtl/crc_word_packer.sv - byte-to-word packer feeding the CRC stage; CRC_PACK_PAD_EN enables byte_last padding
module crc_word_packer
  import crc_pkg::*;
#(
  parameter int         WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter logic [7:0] PAD_BYTE        = 8'h00,
  parameter int         GAP_CYCLES      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [7:0]                             byte_in,
  input  logic                                   byte_valid,
  input  logic                                   byte_last,
  output logic                                   byte_ready,
  output logic [31:0]                            data_out,
  output logic                                   out_valid,
  output logic                                   block_done,
  output logic [$clog2(WORDS_PER_BLOCK+1)-1:0]   word_count
);

  localparam int CW = $clog2(WORDS_PER_BLOCK + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK);
  localparam logic [GW-1:0] GAP_END   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  pack_state_t   state;
  logic [1:0]    lane;
  logic [31:0]   acc_word;
  logic [GW-1:0] gap_cnt;

  logic          accept;
  logic          word_end;
  logic [31:0]   word_next;
  logic [CW-1:0] count_next;

`ifdef CRC_PACK_PAD_EN
`else
  // Frame boundaries do not affect packing in the unpadded build.
  logic unused_last;
  assign unused_last = byte_last;
`endif

  // Accept qualification, next packed word and the count the next emitted word will carry.
  always_comb begin
    accept    = byte_valid && byte_ready;
    word_next = put_lane(acc_word, lane, byte_in);
`ifdef CRC_PACK_PAD_EN
    // acc_word starts each word as all PAD_BYTE, so a short word is already padded.
    word_end  = accept && ((lane == 2'd3) || byte_last);
`else
    word_end  = accept && (lane == 2'd3);
`endif
    // The count of a finished block is shown for one cycle, then restarts from zero.
    count_next = (block_done ? '0 : word_count) + 1'b1;
  end

  // FILL/GAP sequencing, lane packing, word emission and block counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      byte_ready <= 1'b1;
      lane       <= 2'd0;
      acc_word   <= {4{PAD_BYTE}};
      gap_cnt    <= '0;
      data_out   <= 32'h0;
      out_valid  <= 1'b0;
      block_done <= 1'b0;
      word_count <= '0;
    end else begin
      out_valid  <= 1'b0;
      block_done <= 1'b0;
      if (block_done) begin
        word_count <= '0;
      end
      case (state)
        ST_FILL: begin
          if (word_end) begin
            lane       <= 2'd0;
            acc_word   <= {4{PAD_BYTE}};
            data_out   <= word_next;
            out_valid  <= 1'b1;
            word_count <= count_next;
            if (count_next == LAST_WORD) begin
              block_done <= 1'b1;
              if (GAP_CYCLES > 0) begin
                state      <= ST_GAP;
                byte_ready <= 1'b0;
                gap_cnt    <= '0;
              end
            end
          end else if (accept) begin
            lane     <= lane + 2'd1;
            acc_word <= word_next;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_END) begin
            state      <= ST_FILL;
            byte_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_FILL;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/crc_word_packer.md
CRC_WORD_PACKER -- requirements
Module: crc_word_packer

Interface
REQ-001 Parameter WORDS_PER_BLOCK, default 101, SHALL set the number of 32-bit words per CRC block.
REQ-002 Parameter PAD_BYTE, default 8'h00, SHALL set the fill value for unused byte lanes of a flushed partial word.
REQ-003 Parameter GAP_CYCLES, default 2, SHALL set the number of post-block cycles with byte_ready low.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 byte_in  input  8  payload byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_last  input  1  byte_in is the final byte of a frame; qualified by byte_valid.
REQ-009 byte_ready  output  1  packer accepts a byte this cycle.
REQ-010 data_out  output  32  packed word for the downstream CRC stage.
REQ-011 out_valid  output  1  single-cycle strobe, data_out valid.
REQ-012 block_done  output  1  single-cycle strobe coincident with the last word of a block.
REQ-013 word_count  output  $clog2(WORDS_PER_BLOCK+1)  words emitted in the current block.

Function
REQ-014 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-015 Accepted bytes SHALL be packed MSB-first: 1st byte to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-016 out_valid SHALL pulse high for exactly one cycle, the cycle after the 4th byte of a word is accepted; data_out SHALL hold the word until the next out_valid.
REQ-017 There is no downstream backpressure; each out_valid pulse SHALL be treated as consumed.
REQ-018 word_count SHALL increment with each out_valid; on the WORDS_PER_BLOCK-th word block_done SHALL pulse together with out_valid and word_count SHALL return to 0 on the next cycle.
REQ-019 FSM states: FILL (byte_ready=1), GAP (byte_ready=0); reset enters FILL.
REQ-020 FILL->GAP SHALL occur on the edge that issues block_done; GAP->FILL SHALL occur after GAP_CYCLES cycles in GAP.
REQ-021 Bytes presented during GAP SHALL NOT be accepted; the upstream source holds them until byte_ready=1.
REQ-022 A 4th-byte accept and byte_last together SHALL emit that word normally with no extra word.
REQ-023 byte_last with no partial word pending SHALL emit nothing extra.
REQ-024 The byte lane index SHALL wrap 3->0 after each emitted word.

Reset
REQ-025 Reset SHALL force data_out=0, out_valid=0, block_done=0, word_count=0, byte_ready=1 and state FILL, and SHALL clear the byte lane index.
REQ-026 Reset mid-word or mid-block SHALL discard partial bytes and count; the first word after reset SHALL use the next four accepted bytes.

Configuration
REQ-027 With CRC_PACK_PAD_EN defined, byte_last on a partial word SHALL fill the remaining lanes with PAD_BYTE and emit the word the next cycle, counted as a normal word.
REQ-028 Without CRC_PACK_PAD_EN, byte_last SHALL be ignored; partial bytes SHALL stay pending until four bytes are accepted.

Structure
REQ-029 Package crc_pkg SHALL hold the WORDS_PER_BLOCK default (101), the CRC32 polynomial constant 32'hEDB88320, init/xorout 32'hFFFFFFFF and the packer state enum.
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 Bytes 12,34,56,78 (hex) on consecutive cycles -> data_out=32'h12345678, out_valid high one cycle after the 4th accept, word_count=1.
REQ-032 404 consecutive bytes -> 101 out_valid pulses, block_done only with the 101st, byte_ready low 2 cycles after, word_count=0.
REQ-033 byte_valid held high through GAP with byte AA -> not accepted during GAP; accepted on the first FILL cycle as lane [31:24].
REQ-034 With CRC_PACK_PAD_EN: AB, then CD with byte_last -> data_out=32'hABCD0000 one cycle later; without the macro -> no output until two more bytes arrive.
REQ-035 3 bytes, reset pulse, then 01,02,03,04 -> single word 32'h01020304, word_count=1, no earlier out_valid.
